// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: owns scores, serve direction, speed level, pause and
// game-over, and turns the pixel clock into one-cycle ball step enables.
module pong_match_ctrl #(
  parameter int WIN_SCORE    = 9,
  parameter int LVL1_SCORE   = 3,
  parameter int LVL2_SCORE   = 6,
  parameter int DIV_L0       = 250000,
  parameter int DIV_L1       = 166666,
  parameter int DIV_L2       = 125000,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic       start,
  input  logic       pause,
  input  logic       frame_tick,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_step,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] level,
  output logic       paused,
  output logic       game_over
);

  localparam int FRAME_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int FW        = $clog2(FRAME_MAX + 1);

  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, GAME_OVER} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    score_l_reg, score_l_next;
  logic [3:0]    score_r_reg, score_r_next;
  logic [1:0]    level_reg, level_next;
  logic          serve_dir_reg, serve_dir_next;
  logic          paused_reg, paused_next;
  logic [FW-1:0] frame_cnt_reg, frame_cnt_next;
  logic [19:0]   step_cnt_reg, step_cnt_next;
  logic [19:0]   step_last;
  logic          start_edge, pause_edge;
  logic          enter_serve, enter_point;
  logic [1:0]    btn_level, btn_edge;

  // Button edge detectors: bit 0 = start, bit 1 = pause.
  assign btn_level = {pause, start};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic q_reg;
      always_ff @(posedge dclk or negedge clr) begin
        if (!clr) q_reg <= 1'b0;
        else      q_reg <= btn_level[gi];
      end
      assign btn_edge[gi] = btn_level[gi] & ~q_reg;
    end
  endgenerate

  assign start_edge = btn_edge[0];
  assign pause_edge = btn_edge[1];

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= 4'(WIN_SCORE)) ? 4'(WIN_SCORE) : s + 4'd1;
  endfunction

  function automatic logic [1:0] level_of(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] m;
    m = (a > b) ? a : b;
    if (m < 4'(LVL1_SCORE)) return 2'd0;
    if (m < 4'(LVL2_SCORE)) return 2'd1;
    return 2'd2;
  endfunction

  // Level only moves at serve entry, so the divider period is fixed per rally.
  always_comb begin
    case (level_reg)
      2'd0:    step_last = 20'(DIV_L0 - 1);
      2'd1:    step_last = 20'(DIV_L1 - 1);
      default: step_last = 20'(DIV_L2 - 1);
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    score_l_next   = score_l_reg;
    score_r_next   = score_r_reg;
    level_next     = level_reg;
    serve_dir_next = serve_dir_reg;
    paused_next    = paused_reg;
    frame_cnt_next = frame_cnt_reg;
    step_cnt_next  = step_cnt_reg;
    ball_step      = 1'b0;
    ball_reset     = 1'b0;
    enter_serve    = 1'b0;
    enter_point    = 1'b0;

    case (state_reg)
      IDLE, GAME_OVER: begin
        if (start_edge) begin
          score_l_next   = 4'd0;
          score_r_next   = 4'd0;
          serve_dir_next = 1'b1;
          enter_serve    = 1'b1;
        end
      end

      SERVE: begin
        if (pause_edge) paused_next = ~paused_reg;
        if (!paused_reg && frame_tick) begin
          if (frame_cnt_reg >= FW'(SERVE_FRAMES - 1)) begin
            state_next     = PLAY;
            frame_cnt_next = '0;
            step_cnt_next  = '0;
          end else begin
            frame_cnt_next = frame_cnt_reg + FW'(1);
          end
        end
      end

      PLAY: begin
        if (miss_left) begin
          score_r_next   = sat_inc(score_r_reg);
          serve_dir_next = 1'b0;
          enter_point    = 1'b1;
        end else if (miss_right) begin
          score_l_next   = sat_inc(score_l_reg);
          serve_dir_next = 1'b1;
          enter_point    = 1'b1;
        end else begin
          if (pause_edge) paused_next = ~paused_reg;
          if (!paused_reg) begin
            if (step_cnt_reg == step_last) begin
              ball_step     = 1'b1;
              step_cnt_next = '0;
            end else begin
              step_cnt_next = step_cnt_reg + 20'd1;
            end
          end
        end
      end

      POINT: begin
        if (frame_tick) begin
          if (frame_cnt_reg >= FW'(POINT_FRAMES - 1)) begin
            if (score_l_reg == 4'(WIN_SCORE) || score_r_reg == 4'(WIN_SCORE)) begin
              state_next     = GAME_OVER;
              frame_cnt_next = '0;
            end else begin
              enter_serve = 1'b1;
            end
          end else begin
            frame_cnt_next = frame_cnt_reg + FW'(1);
          end
        end
      end

      default: state_next = IDLE;
    endcase

    // A tick that did not cause the transition belongs to the new phase.
    if (enter_point) begin
      state_next     = POINT;
      paused_next    = 1'b0;
      step_cnt_next  = '0;
      frame_cnt_next = frame_tick ? FW'(1) : FW'(0);
    end

    if (enter_serve) begin
      state_next     = SERVE;
      ball_reset     = 1'b1;
      paused_next    = 1'b0;
      step_cnt_next  = '0;
      level_next     = level_of(score_l_next, score_r_next);
      frame_cnt_next = (frame_tick && state_reg != POINT) ? FW'(1) : FW'(0);
    end
  end

  always_ff @(posedge dclk or negedge clr) begin
    if (!clr) begin
      state_reg     <= IDLE;
      score_l_reg   <= 4'd0;
      score_r_reg   <= 4'd0;
      level_reg     <= 2'd0;
      serve_dir_reg <= 1'b1;
      paused_reg    <= 1'b0;
      frame_cnt_reg <= '0;
      step_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      score_l_reg   <= score_l_next;
      score_r_reg   <= score_r_next;
      level_reg     <= level_next;
      serve_dir_reg <= serve_dir_next;
      paused_reg    <= paused_next;
      frame_cnt_reg <= frame_cnt_next;
      step_cnt_reg  <= step_cnt_next;
    end
  end

  assign serve_dir = serve_dir_reg;
  assign score_l   = score_l_reg;
  assign score_r   = score_r_reg;
  assign level     = level_reg;
  assign paused    = paused_reg;
  assign game_over = (state_reg == GAME_OVER);

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed-plus-random bench for pong_match_ctrl, checked every cycle against a
// rule-level match model kept here.
module tb_pong_match_ctrl;

  localparam int W   = 3;
  localparam int L1  = 1;
  localparam int L2  = 2;
  localparam int D0  = 10;
  localparam int D1  = 6;
  localparam int D2  = 4;
  localparam int SF  = 2;
  localparam int PF  = 2;
  localparam int TP  = 20;

  localparam int PH_IDLE  = 0;
  localparam int PH_SERVE = 1;
  localparam int PH_PLAY  = 2;
  localparam int PH_POINT = 3;
  localparam int PH_OVER  = 4;

  logic       dclk = 1'b0;
  logic       clr, start, pause, frame_tick, miss_left, miss_right;
  logic       ball_step, ball_reset, serve_dir, paused, game_over;
  logic [3:0] score_l, score_r;
  logic [1:0] level;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: match phase, scores, and elapsed unpaused play cycles of this rally.
  int m_phase, m_sl, m_sr, m_lvl, m_dir, m_paused, m_frames, m_play;
  bit m_sprev, m_pprev;

  always #5 dclk = ~dclk;

  pong_match_ctrl #(
    .WIN_SCORE(W), .LVL1_SCORE(L1), .LVL2_SCORE(L2),
    .DIV_L0(D0), .DIV_L1(D1), .DIV_L2(D2),
    .SERVE_FRAMES(SF), .POINT_FRAMES(PF)
  ) dut (
    .dclk(dclk), .clr(clr), .start(start), .pause(pause),
    .frame_tick(frame_tick), .miss_left(miss_left), .miss_right(miss_right),
    .ball_step(ball_step), .ball_reset(ball_reset), .serve_dir(serve_dir),
    .score_l(score_l), .score_r(score_r), .level(level),
    .paused(paused), .game_over(game_over)
  );

  function automatic int div_of(int l);
    return (l == 0) ? D0 : ((l == 1) ? D1 : D2);
  endfunction

  function automatic int level_for(int a, int b);
    int m;
    m = (a > b) ? a : b;
    return (m >= L2) ? 2 : ((m >= L1) ? 1 : 0);
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_sl = 0; m_sr = 0; m_lvl = 0; m_dir = 1;
    m_paused = 0; m_frames = 0; m_play = 0; m_sprev = 0; m_pprev = 0;
  endtask

  task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h required %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    n_vec++;
    assert (obs == expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive, advance the model, compare at the falling edge.
  task automatic step(input bit s, input bit p, input bit ml, input bit mr, input string tag);
    logic [14:0] expv;
    bit tk, se, pe, st, rs;
    int from;
    start = s; pause = p; miss_left = ml; miss_right = mr;
    tk = ((cyc % TP) == TP - 1);
    frame_tick = tk;
    st = 0; rs = 0;
    if (!clr) model_reset();
    expv = {2'b00, 1'(m_dir), 4'(m_sl), 4'(m_sr), 2'(m_lvl), 1'(m_paused), 1'(m_phase == PH_OVER)};
    if (clr) begin
      se = s && !m_sprev;
      pe = p && !m_pprev;
      from = m_phase;
      if ((m_phase == PH_IDLE || m_phase == PH_OVER) && se) begin
        m_sl = 0; m_sr = 0; m_dir = 1; rs = 1;
      end else if (m_phase == PH_SERVE) begin
        if (!m_paused && tk) m_frames++;
        if (pe) m_paused = !m_paused;
        if (m_frames >= SF) begin m_phase = PH_PLAY; m_frames = 0; m_play = 0; end
      end else if (m_phase == PH_PLAY) begin
        if (ml || mr) begin
          if (ml) begin m_sr = (m_sr + 1 > W) ? W : m_sr + 1; m_dir = 0; end
          else    begin m_sl = (m_sl + 1 > W) ? W : m_sl + 1; m_dir = 1; end
          m_phase = PH_POINT; m_paused = 0; m_frames = tk ? 1 : 0;
        end else begin
          if (!m_paused) begin
            st = ((m_play % div_of(m_lvl)) == div_of(m_lvl) - 1);
            m_play++;
          end
          if (pe) m_paused = !m_paused;
        end
      end else if (m_phase == PH_POINT && tk) begin
        m_frames++;
        if (m_frames >= PF) begin
          if (m_sl == W || m_sr == W) begin m_phase = PH_OVER; m_frames = 0; end
          else rs = 1;
        end
      end
      if (rs) begin
        m_phase = PH_SERVE; m_paused = 0; m_play = 0;
        m_lvl = level_for(m_sl, m_sr);
        m_frames = (tk && from != PH_POINT) ? 1 : 0;
      end
      m_sprev = s; m_pprev = p;
    end
    expv[14] = st;
    expv[13] = rs;
    @(negedge dclk);
    check(tag, {ball_step, ball_reset, serve_dir, score_l, score_r, level, paused, game_over}, expv);
    @(posedge dclk);
    #1;
    cyc++;
  endtask

  task automatic wait_phase(input int ph, input int budget, input string tag);
    int n;
    n = 0;
    while (m_phase != ph && n < budget) begin
      step(0, 0, 0, 0, tag);
      n++;
    end
    if (m_phase != ph) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: timeout, phase %0d required %0d", tag, m_phase, ph);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    bit  rs_lvl, rp_lvl;
    clr = 1'b0; start = 0; pause = 0; frame_tick = 0; miss_left = 0; miss_right = 0;
    model_reset();

    repeat (3) step(0, 0, 0, 0, "reset");
    clr = 1'b1;
    repeat (3) step(0, 0, 0, 0, "idle");

    // Match start and first rally at level 0.
    k = $urandom_range(1, 4);
    repeat (k) step(1, 0, 0, 0, "start_serve");
    chk("start_score_l", score_l, 0);
    chk("start_serve_dir", serve_dir, 1);
    wait_phase(PH_PLAY, 200, "wait_play1");
    repeat (35) step(0, 0, 0, 0, "play_l0");
    repeat ($urandom_range(0, 9)) step(0, 0, 0, 0, "play_l0");
    step(0, 0, 0, 1, "miss_right1");
    chk("miss_right_score_l", score_l, 1);
    chk("miss_right_dir", serve_dir, 1);
    wait_phase(PH_SERVE, 200, "wait_serve2");
    chk("serve2_level", level, 1);
    wait_phase(PH_PLAY, 200, "wait_play2");
    repeat (20) step(0, 0, 0, 0, "play_l1");

    // Pause held mid-rally, then resumed by a second edge.
    repeat ($urandom_range(1, 5)) step(0, 0, 0, 0, "pre_pause");
    repeat (50) step(0, 1, 0, 0, "pause_hold");
    chk("pause_active", paused, 1);
    repeat (3) step(0, 0, 0, 0, "pause_release");
    step(0, 1, 0, 0, "pause_resume");
    repeat (20) step(0, 0, 0, 0, "resumed");

    // Both misses together: left miss wins.
    step(0, 0, 1, 1, "miss_both");
    chk("both_score_r", score_r, 1);
    chk("both_score_l", score_l, 1);
    chk("both_dir", serve_dir, 0);

    // Drive score_l to the winning score.
    wait_phase(PH_PLAY, 200, "wait_play3");
    repeat ($urandom_range(2, 12)) step(0, 0, 0, 0, "play3");
    step(0, 0, 0, 1, "miss_right2");
    wait_phase(PH_PLAY, 200, "wait_play4");
    repeat ($urandom_range(2, 12)) step(0, 0, 0, 0, "play_l2");
    step(0, 0, 0, 1, "miss_right3");
    wait_phase(PH_OVER, 200, "wait_over");
    chk("over_flag", game_over, 1);
    chk("over_score_l", score_l, W);
    repeat (10) step(0, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, "over_misses");
    chk("over_hold_score_l", score_l, W);
    step(1, 0, 0, 0, "restart");
    chk("restart_score_l", score_l, 0);
    chk("restart_score_r", score_r, 0);
    chk("restart_level", level, 0);
    chk("restart_over", game_over, 0);
    step(0, 0, 0, 0, "restart");

    // Asynchronous clear with the step counter at 5.
    wait_phase(PH_PLAY, 200, "wait_play5");
    k = 0;
    while (!(m_phase == PH_PLAY && (m_play % div_of(m_lvl)) == 5) && k < 100) begin
      step(0, 0, 0, 0, "to_cnt5");
      k++;
    end
    clr = 1'b0;
    step(0, 0, 0, 0, "clr_async");
    step(0, 0, 0, 0, "clr_hold");
    clr = 1'b1;
    repeat (30) step(0, 0, 0, 0, "post_clr_idle");

    // Random soak over whole matches.
    rs_lvl = 0; rp_lvl = 0;
    repeat (800) begin
      if ($urandom_range(0, 11) == 0) rs_lvl = !rs_lvl;
      if ($urandom_range(0, 14) == 0) rp_lvl = !rp_lvl;
      step(rs_lvl, rp_lvl, $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0, "soak");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
